// File: rtl/eth_tx_sequencer.sv
// eth_tx_sequencer
//   Drives a KSZ-style Ethernet controller through the register and QMU
//   accesses needed to push one frame into the transmit queue: poll TXMIR
//   for room, mask interrupts, open the QMU data window, stream header and
//   payload words as dummy writes, close the window, enqueue, restore IER.
//
// Ports
//   clk40m      single clock, rising edge
//   reset       asynchronous, active-low
//   txStart     one-cycle frame request, txLen sampled with it
//   txLen       frame byte length
//   txBusy      sequence in progress
//   txDone      one-cycle pulse, frame enqueued
//   txErr       one-cycle pulse, frame rejected or out of retries
//   txStatus    00 idle, 01 busy, 10 last done, 11 last error
//   frameCount  frames successfully enqueued (wraps)
//   bufAddr     payload word index into the caller's buffer
//   bufData     payload word, valid one clock after bufAddr changes
//   cmdReq/cmdWr/cmdOffset/cmdDummy/cmdWData  access request to controller
//   cmdAck/cmdRData                           access completion and read data
module eth_tx_sequencer #(
  parameter int          LEN_W     = 11,
  parameter int          ADDR_W    = 10,
  parameter logic [15:0] IER_VALUE = 16'h6000,
  parameter int          RETRY_MAX = 8,
  parameter int          POLL_GAP  = 256
) (
  input  logic              clk40m,
  input  logic              reset,
  input  logic              txStart,
  input  logic [LEN_W-1:0]  txLen,
  output logic              txBusy,
  output logic              txDone,
  output logic              txErr,
  output logic [1:0]        txStatus,
  output logic [15:0]       frameCount,
  output logic [ADDR_W-1:0] bufAddr,
  input  logic [15:0]       bufData,
  output logic              cmdReq,
  output logic              cmdWr,
  output logic [7:0]        cmdOffset,
  output logic              cmdDummy,
  output logic [15:0]       cmdWData,
  input  logic              cmdAck,
  input  logic [15:0]       cmdRData
);

  localparam int RET_W = $clog2(RETRY_MAX + 1);
  localparam int GAP_W = $clog2(POLL_GAP + 1);
  localparam logic [RET_W-1:0] RETRY_LIM = RET_W'(RETRY_MAX);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(POLL_GAP - 1);

  typedef enum logic [4:0] {
    S_IDLE, S_POLL, S_CHECK, S_GAP, S_IER_OFF, S_RXQ_RD, S_RXQ_SET,
    S_HDR_CTL, S_HDR_LEN, S_DATA_ADDR, S_DATA_WR, S_RXQ_RD2, S_RXQ_CLR,
    S_TXQ_RD, S_TXQ_ENQ, S_IER_ON, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         rdata_q;
  logic [LEN_W-1:0]    len_q;
  logic [ADDR_W:0]     words_left;
  logic                addr_phase;
  logic [RET_W-1:0]    retries;
  logic [GAP_W-1:0]    gap_cnt;
  logic [5:0]          frame_id;
  logic [5:0]          cur_id;

  logic                acked;
  logic                len_ok;
  logic                poll_pass;
  logic [RET_W-1:0]    retry_inc;
  logic [LEN_W:0]      len_plus;
  logic [ADDR_W:0]     words_calc;

  logic                launch;
  logic                acc_wr;
  logic [7:0]          acc_off;
  logic                acc_dummy;
  logic [15:0]         acc_wdata;

  // An ack only counts while a request is actually outstanding.
  assign acked     = cmdReq && cmdAck;
  assign len_ok    = (txLen != '0) && (32'(txLen) <= 32'd2000);
  assign poll_pass = rdata_q[12:0] >= (13'(len_q) + 13'd4);
  assign retry_inc = retries + 1'b1;

  // Round the byte length up to a 4-byte multiple, then count 16-bit words.
  assign len_plus   = {1'b0, txLen} + (LEN_W+1)'(3);
  assign words_calc = (ADDR_W+1)'({len_plus[LEN_W:2], 1'b0});

  assign txBusy = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign txDone = (state_q == S_DONE);
  assign txErr  = (state_q == S_ERR);

  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the access descriptor for the current state. Every
  // access state launches on its first cycle (cmdReq is always low on entry
  // because the previous ack dropped it) and advances on the ack.
  always_comb begin
    state_d   = state_q;
    launch    = 1'b0;
    acc_wr    = 1'b0;
    acc_off   = 8'h00;
    acc_dummy = 1'b0;
    acc_wdata = 16'h0000;
    case (state_q)
      S_IDLE: if (txStart) state_d = len_ok ? S_POLL : S_ERR;
      S_POLL: begin
        launch  = !cmdReq;
        acc_off = 8'h78;
        if (acked) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (poll_pass)               state_d = S_IER_OFF;
        else if (retry_inc == RETRY_LIM) state_d = S_ERR;
        else                         state_d = S_GAP;
      end
      S_GAP: if (gap_cnt == GAP_LAST) state_d = S_POLL;
      S_IER_OFF: begin
        launch  = !cmdReq;
        acc_wr  = 1'b1;
        acc_off = 8'h90;
        if (acked) state_d = S_RXQ_RD;
      end
      S_RXQ_RD: begin
        launch  = !cmdReq;
        acc_off = 8'h82;
        if (acked) state_d = S_RXQ_SET;
      end
      S_RXQ_SET: begin
        launch    = !cmdReq;
        acc_wr    = 1'b1;
        acc_off   = 8'h82;
        acc_wdata = rdata_q | 16'h0008;
        if (acked) state_d = S_HDR_CTL;
      end
      S_HDR_CTL: begin
        launch    = !cmdReq;
        acc_wr    = 1'b1;
        acc_dummy = 1'b1;
        acc_wdata = {10'b1000000000, cur_id};
        if (acked) state_d = S_HDR_LEN;
      end
      S_HDR_LEN: begin
        launch    = !cmdReq;
        acc_wr    = 1'b1;
        acc_dummy = 1'b1;
        acc_wdata = 16'(len_q);
        if (acked) state_d = S_DATA_ADDR;
      end
      // Two cycles of address hold; the second one captures bufData.
      S_DATA_ADDR: begin
        launch    = addr_phase;
        acc_wr    = 1'b1;
        acc_dummy = 1'b1;
        acc_wdata = bufData;
        if (addr_phase) state_d = S_DATA_WR;
      end
      S_DATA_WR: begin
        if (acked) state_d = (words_left == (ADDR_W+1)'(1)) ? S_RXQ_RD2 : S_DATA_ADDR;
      end
      S_RXQ_RD2: begin
        launch  = !cmdReq;
        acc_off = 8'h82;
        if (acked) state_d = S_RXQ_CLR;
      end
      S_RXQ_CLR: begin
        launch    = !cmdReq;
        acc_wr    = 1'b1;
        acc_off   = 8'h82;
        acc_wdata = rdata_q & ~16'h0008;
        if (acked) state_d = S_TXQ_RD;
      end
      S_TXQ_RD: begin
        launch  = !cmdReq;
        acc_off = 8'h80;
        if (acked) state_d = S_TXQ_ENQ;
      end
      S_TXQ_ENQ: begin
        launch    = !cmdReq;
        acc_wr    = 1'b1;
        acc_off   = 8'h80;
        acc_wdata = rdata_q | 16'h0001;
        if (acked) state_d = S_IER_ON;
      end
      S_IER_ON: begin
        launch    = !cmdReq;
        acc_wr    = 1'b1;
        acc_off   = 8'h90;
        acc_wdata = IER_VALUE;
        if (acked) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Access port, frame bookkeeping and the counters that pace the sequence.
  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) begin
      cmdReq     <= 1'b0;
      cmdWr      <= 1'b0;
      cmdOffset  <= 8'h00;
      cmdDummy   <= 1'b0;
      cmdWData   <= 16'h0000;
      rdata_q    <= 16'h0000;
      len_q      <= '0;
      words_left <= '0;
      bufAddr    <= '0;
      addr_phase <= 1'b0;
      retries    <= '0;
      gap_cnt    <= '0;
      frame_id   <= 6'd0;
      cur_id     <= 6'd0;
      frameCount <= 16'h0000;
      txStatus   <= 2'b00;
    end else begin
      if (launch) begin
        cmdReq    <= 1'b1;
        cmdWr     <= acc_wr;
        cmdOffset <= acc_off;
        cmdDummy  <= acc_dummy;
        cmdWData  <= acc_wdata;
      end else if (acked) begin
        cmdReq <= 1'b0;
        if (!cmdWr) rdata_q <= cmdRData;
      end

      case (state_q)
        S_IDLE: begin
          if (txStart) begin
            if (len_ok) begin
              len_q      <= txLen;
              words_left <= words_calc;
              retries    <= '0;
              cur_id     <= frame_id;
              frame_id   <= frame_id + 6'd1;
              txStatus   <= 2'b01;
            end else begin
              txStatus <= 2'b11;
            end
          end
        end
        S_CHECK: begin
          if (!poll_pass) begin
            retries <= retry_inc;
            gap_cnt <= '0;
            if (retry_inc == RETRY_LIM) txStatus <= 2'b11;
          end
        end
        S_GAP:       gap_cnt <= gap_cnt + 1'b1;
        S_HDR_LEN: begin
          if (acked) begin
            bufAddr    <= '0;
            addr_phase <= 1'b0;
          end
        end
        S_DATA_ADDR: addr_phase <= ~addr_phase;
        S_DATA_WR: begin
          if (acked) begin
            words_left <= words_left - 1'b1;
            if (words_left != (ADDR_W+1)'(1)) bufAddr <= bufAddr + 1'b1;
          end
        end
        S_IER_ON: begin
          if (acked) begin
            frameCount <= frameCount + 16'd1;
            txStatus   <= 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_sequencer.sv
// tb_eth_tx_sequencer
//   Randomized scoreboard bench for eth_tx_sequencer. The stimulus side
//   computes each frame's expected access list and outcome from the frame
//   rules and queues them; a monitor pops and compares on every access
//   launch and every done/error pulse. A device model answers accesses
//   with random latency and a buffer model returns payload one clock late.
module tb_eth_tx_sequencer;

  localparam int          LEN_W     = 11;
  localparam int          ADDR_W    = 10;
  localparam int          RETRY_MAX = 8;
  localparam int          POLL_GAP  = 256;
  localparam logic [15:0] IER_VALUE = 16'h6000;

  logic              clk40m;
  logic              reset;
  logic              txStart;
  logic [LEN_W-1:0]  txLen;
  logic              txBusy, txDone, txErr;
  logic [1:0]        txStatus;
  logic [15:0]       frameCount;
  logic [ADDR_W-1:0] bufAddr;
  logic [15:0]       bufData;
  logic              cmdReq, cmdWr, cmdDummy, cmdAck;
  logic [7:0]        cmdOffset;
  logic [15:0]       cmdWData, cmdRData;

  eth_tx_sequencer #(
    .LEN_W(LEN_W), .ADDR_W(ADDR_W), .IER_VALUE(IER_VALUE),
    .RETRY_MAX(RETRY_MAX), .POLL_GAP(POLL_GAP)
  ) dut (
    .clk40m(clk40m), .reset(reset), .txStart(txStart), .txLen(txLen),
    .txBusy(txBusy), .txDone(txDone), .txErr(txErr), .txStatus(txStatus),
    .frameCount(frameCount), .bufAddr(bufAddr), .bufData(bufData),
    .cmdReq(cmdReq), .cmdWr(cmdWr), .cmdOffset(cmdOffset), .cmdDummy(cmdDummy),
    .cmdWData(cmdWData), .cmdAck(cmdAck), .cmdRData(cmdRData)
  );

  initial begin
    clk40m = 1'b0;
    forever #5 clk40m = ~clk40m;
  end

  typedef struct packed {
    logic        wr;
    logic [7:0]  off;
    logic        dummy;
    logic [15:0] data;
  } acc_t;

  typedef struct packed {
    logic        err;
    logic [15:0] fc;
  } evt_t;

  acc_t        expAcc[$];
  evt_t        expEvt[$];
  int          testsRun = 0;
  int          testsFailed = 0;
  logic [15:0] mem [0:1023];
  logic [15:0] regs [0:255];
  int          pollFailsLeft = 0;
  logic [15:0] pollLow = 16'h0000;
  logic [15:0] pollHigh = 16'h0000;
  int          modelFrameCount = 0;
  int          modelFrameId = 0;
  int          dummyCount = 0;
  int          cycle = 0;
  int          lastPollCycle = -1;
  int          accIndex = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Controller model: acks each request after 0..3 cycles, keeps a register
  // file updated by real writes, and throws stray acks when idle.
  initial begin : device
    int delay;
    bit sent;
    cmdAck = 1'b0;
    cmdRData = 16'h0000;
    sent = 1'b0;
    delay = 0;
    forever begin
      @(negedge clk40m);
      cmdAck = 1'b0;
      if (!reset) begin
        sent = 1'b0;
        delay = $urandom_range(0, 3);
      end else if (cmdReq && !sent) begin
        if (delay == 0) begin
          cmdAck = 1'b1;
          sent = 1'b1;
          delay = $urandom_range(0, 3);
          if (!cmdWr) begin
            if (cmdOffset == 8'h78) begin
              cmdRData = (pollFailsLeft > 0) ? pollLow : pollHigh;
              if (pollFailsLeft > 0) pollFailsLeft--;
            end else begin
              cmdRData = regs[cmdOffset];
            end
          end else begin
            cmdRData = 16'($urandom);
            if (!cmdDummy) regs[cmdOffset] = cmdWData;
          end
        end else begin
          delay--;
        end
      end else if (!cmdReq) begin
        sent = 1'b0;
        if ($urandom_range(0, 7) == 0) begin
          cmdAck = 1'b1;
          cmdRData = 16'hFFFF;
        end
      end
    end
  end

  // Payload buffer: data for an address appears one full clock later.
  initial begin : bufModel
    logic [ADDR_W-1:0] prevAddr;
    prevAddr = '0;
    bufData = 16'h0000;
    forever begin
      @(negedge clk40m);
      bufData = mem[prevAddr];
      prevAddr = bufAddr;
    end
  end

  // Monitor: compares every launched access and every outcome pulse.
  initial begin : monitor
    acc_t act, exp, launched;
    evt_t ev;
    bit   prevReq, holdBad, ok;
    prevReq = 1'b0;
    holdBad = 1'b0;
    launched = '0;
    forever begin
      @(posedge clk40m);
      #1;
      cycle++;
      if (!reset) begin
        prevReq = 1'b0;
        holdBad = 1'b0;
      end else begin
        act = '{wr: cmdWr, off: cmdOffset, dummy: cmdDummy, data: cmdWData};
        if (cmdReq && !prevReq) begin
          launched = act;
          accIndex++;
          if (cmdDummy) dummyCount++;
          testsRun++;
          if (expAcc.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL access #%0d unexpected: got wr=%0b off=%02h dummy=%0b data=%04h, expected none",
                     accIndex, act.wr, act.off, act.dummy, act.data);
          end else begin
            exp = expAcc.pop_front();
            ok = (act.wr == exp.wr) && (act.dummy == exp.dummy) &&
                 (exp.dummy || act.off == exp.off) && (!exp.wr || act.data == exp.data);
            if (!ok) begin
              testsFailed++;
              $display("[TB] FAIL access #%0d: got wr=%0b off=%02h dummy=%0b data=%04h, expected wr=%0b off=%02h dummy=%0b data=%04h",
                       accIndex, act.wr, act.off, act.dummy, act.data, exp.wr, exp.off, exp.dummy, exp.data);
            end
          end
          if (!cmdWr && cmdOffset == 8'h78) begin
            if (lastPollCycle >= 0)
              checkOutput("poll spacing>=gap", 64'(cycle - lastPollCycle >= POLL_GAP), 64'd1);
            lastPollCycle = cycle;
          end
        end else if (cmdReq && prevReq && act != launched) begin
          holdBad = 1'b1;
        end
        if (!cmdReq && prevReq) begin
          checkOutput("fields held while req", 64'(holdBad), 64'd0);
          checkOutput("req drops after ack", 64'(cmdAck), 64'd1);
          holdBad = 1'b0;
        end
        if (txDone || txErr) begin
          testsRun++;
          if (expEvt.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL outcome unexpected: got done=%0b err=%0b, expected none", txDone, txErr);
          end else begin
            ev = expEvt.pop_front();
            ok = (txErr == ev.err) && (txDone == !ev.err) &&
                 (txStatus == (ev.err ? 2'b11 : 2'b10)) && (frameCount == ev.fc);
            if (!ok) begin
              testsFailed++;
              $display("[TB] FAIL outcome: got done=%0b err=%0b status=%0b fc=%0d, expected err=%0b fc=%0d",
                       txDone, txErr, txStatus, frameCount, ev.err, ev.fc);
            end
          end
          lastPollCycle = -1;
        end
        prevReq = cmdReq;
      end
    end
  end

  function automatic acc_t rd(input logic [7:0] off);
    return '{wr: 1'b0, off: off, dummy: 1'b0, data: 16'h0000};
  endfunction

  function automatic acc_t wrReg(input logic [7:0] off, input logic [15:0] d);
    return '{wr: 1'b1, off: off, dummy: 1'b0, data: d};
  endfunction

  function automatic acc_t wrDummy(input logic [15:0] d);
    return '{wr: 1'b1, off: 8'h00, dummy: 1'b1, data: d};
  endfunction

  // Queue the expected accesses and outcome of one frame, then request it.
  task automatic applyStimulus(input int len, input int fails, input logic [15:0] lo, input logic [15:0] hi);
    int words, passAt;
    logic [15:0] pv, r82, r80;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    regs[8'h82] = 16'($urandom);
    regs[8'h80] = 16'($urandom);
    r82 = regs[8'h82];
    r80 = regs[8'h80];
    pollFailsLeft = fails;
    pollLow = lo;
    pollHigh = hi;
    lastPollCycle = -1;
    if (len == 0 || len > 2000) begin
      expEvt.push_back('{err: 1'b1, fc: 16'(modelFrameCount)});
    end else begin
      passAt = -1;
      for (int p = 0; p < RETRY_MAX; p++) begin
        pv = (p < fails) ? lo : hi;
        if (int'(pv[12:0]) >= len + 4) begin
          passAt = p;
          break;
        end
      end
      for (int p = 0; p < ((passAt < 0) ? RETRY_MAX : passAt + 1); p++) expAcc.push_back(rd(8'h78));
      if (passAt < 0) begin
        expEvt.push_back('{err: 1'b1, fc: 16'(modelFrameCount)});
      end else begin
        words = ((len + 3) / 4) * 2;
        expAcc.push_back(wrReg(8'h90, 16'h0000));
        expAcc.push_back(rd(8'h82));
        expAcc.push_back(wrReg(8'h82, r82 | 16'h0008));
        expAcc.push_back(wrDummy(16'h8000 | 16'(modelFrameId % 64)));
        expAcc.push_back(wrDummy(16'(len)));
        for (int w = 0; w < words; w++) expAcc.push_back(wrDummy(mem[w]));
        expAcc.push_back(rd(8'h82));
        expAcc.push_back(wrReg(8'h82, r82 & ~16'h0008));
        expAcc.push_back(rd(8'h80));
        expAcc.push_back(wrReg(8'h80, r80 | 16'h0001));
        expAcc.push_back(wrReg(8'h90, IER_VALUE));
        modelFrameCount++;
        expEvt.push_back('{err: 1'b0, fc: 16'(modelFrameCount)});
      end
      modelFrameId++;
    end
    @(negedge clk40m);
    txLen = LEN_W'(len);
    txStart = 1'b1;
    @(posedge clk40m);
    #1;
    if (len == 0 || len > 2000) begin
      checkOutput("reject err one cycle later", 64'(txErr), 64'd1);
      checkOutput("reject not busy", 64'(txBusy), 64'd0);
    end else begin
      checkOutput("busy after accept", 64'(txBusy), 64'd1);
    end
    @(negedge clk40m);
    txStart = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while ((expAcc.size() != 0 || expEvt.size() != 0 || txBusy) && n < 20000) begin
      @(negedge clk40m);
      n++;
    end
    if (n >= 20000) begin
      checkOutput({name, " completion"}, 64'd0, 64'd1);
      expAcc.delete();
      expEvt.delete();
    end
    repeat (2) @(negedge clk40m);
  endtask

  task automatic waitDummies(input int target, input string name);
    int n;
    n = 0;
    while (dummyCount < target && n < 5000) begin
      @(negedge clk40m);
      n++;
    end
    if (n >= 5000) checkOutput({name, " reached DATA"}, 64'd0, 64'd1);
  endtask

  function automatic logic [63:0] allOutputs();
    return 64'({txBusy, txDone, txErr, txStatus, frameCount, bufAddr,
                cmdReq, cmdWr, cmdOffset, cmdDummy, cmdWData});
  endfunction

  initial begin : stimulus
    int len, fails, lowCap, hiLow;
    logic [15:0] lo, hi;
    for (int i = 0; i < 256; i++) regs[i] = 16'h0000;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    reset = 1'b0;
    txStart = 1'b0;
    txLen = '0;
    repeat (3) @(negedge clk40m);
    checkOutput("outputs in reset", allOutputs(), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk40m);
    checkOutput("status idle after reset", 64'(txStatus), 64'd0);

    // Directed reference frame, then odd and minimum lengths.
    applyStimulus(60, 0, 16'h0000, 16'h0800);
    waitIdle("len60");
    checkOutput("frameCount after first", 64'(frameCount), 64'd1);
    applyStimulus(61, 0, 16'h0000, 16'h0800);
    waitIdle("len61");
    applyStimulus(1, 0, 16'h0000, 16'h0800);
    waitIdle("len1");

    // Largest length with TXMIR exactly at the threshold, upper bits set.
    applyStimulus(2000, 1, 16'hE000 | 16'd2003, 16'hE000 | 16'd2004);
    waitIdle("len2000");

    // Random frames with a few failed polls before room appears.
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 300);
      fails = $urandom_range(0, 2);
      lowCap = len + 3;
      hiLow = $urandom_range(len + 4, 8191);
      lo = {3'($urandom_range(0, 7)), 13'($urandom_range(0, lowCap))};
      hi = {3'($urandom_range(0, 7)), 13'(hiLow)};
      applyStimulus(len, fails, lo, hi);
      waitIdle("random frame");
    end

    // TXMIR never has room: every poll fails.
    applyStimulus(60, 100, 16'h0010, 16'h0010);
    waitIdle("retry exhaust");
    checkOutput("status after exhaust", 64'(txStatus), 64'd3);

    // Illegal lengths.
    applyStimulus(0, 0, 16'h0000, 16'h1FFF);
    waitIdle("len0");
    applyStimulus(2001, 0, 16'h0000, 16'h1FFF);
    waitIdle("len2001");
    checkOutput("status after reject", 64'(txStatus), 64'd3);

    // txStart while streaming payload must not disturb the frame.
    applyStimulus(40, 0, 16'h0000, 16'h0800);
    waitDummies(dummyCount + 5, "busy start");
    checkOutput("status busy", 64'(txStatus), 64'd1);
    txLen = LEN_W'(2000);
    txStart = 1'b1;
    @(negedge clk40m);
    txStart = 1'b0;
    waitIdle("busy start");

    // Reset in the middle of the payload, then three back-to-back frames.
    applyStimulus(40, 0, 16'h0000, 16'h0800);
    waitDummies(dummyCount + 4, "mid reset");
    reset = 1'b0;
    #1;
    checkOutput("outputs on mid reset", allOutputs(), 64'd0);
    expAcc.delete();
    expEvt.delete();
    modelFrameCount = 0;
    modelFrameId = 0;
    repeat (3) @(negedge clk40m);
    reset = 1'b1;
    @(negedge clk40m);
    for (int f = 0; f < 3; f++) begin
      applyStimulus($urandom_range(1, 80), 0, 16'h0000, 16'h1FFF);
      waitIdle("back-to-back");
    end
    checkOutput("frameCount after reset run", 64'(frameCount), 64'd3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/eth_tx_sequencer.md
ETH_TX_SEQUENCER -- requirements
Module: eth_tx_sequencer

Interface
REQ-001 SHALL have parameter LEN_W, default 11: width of frame byte length.
REQ-002 SHALL have parameter ADDR_W, default 10: width of payload buffer word address.
REQ-003 SHALL have parameter IER_VALUE, default 16'h6000: interrupt enable value restored after transmit.
REQ-004 SHALL have parameter RETRY_MAX, default 8: TXQ memory polls before error.
REQ-005 SHALL have parameter POLL_GAP, default 256: idle clocks between TXQ memory polls.
REQ-006 SHALL have ports:
- clk40m  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- txStart  in  1  one-cycle request to send a frame.
- txLen  in  LEN_W  frame byte length, sampled with txStart.
- txBusy  out  1  sequence in progress.
- txDone  out  1  one-cycle pulse, frame enqueued.
- txErr  out  1  one-cycle pulse, frame rejected or aborted.
- txStatus  out  2  00 idle, 01 busy, 10 last done, 11 last error.
- frameCount  out  16  frames successfully enqueued, wraps.
- bufAddr  out  ADDR_W  payload word index.
- bufData  in  16  payload word, valid 1 clock after bufAddr changes.
- cmdReq  out  1  register/dummy access request.
- cmdWr  out  1  1 write, 0 read.
- cmdOffset  out  8  controller register offset.
- cmdDummy  out  1  access targets the QMU data port.
- cmdWData  out  16  write data.
- cmdAck  in  1  one-cycle completion strobe.
- cmdRData  in  16  read data, valid with cmdAck.

Function
REQ-007 SHALL hold cmdWr, cmdOffset, cmdDummy and cmdWData stable while cmdReq is high, and drop cmdReq on the cycle after cmdAck.
REQ-008 SHALL leave cmdReq low for at least one cycle between accesses; cmdAck while cmdReq is low SHALL be ignored.
REQ-009 SHALL accept txStart only in IDLE; txStart while busy is ignored, with no effect on the latched length.
REQ-010 SHALL reject txLen==0 or txLen>2000: txErr pulse one cycle after txStart, txStatus=11, no accesses.
REQ-011 SHALL compute words = ((txLen+3) & ~3) >> 1 and latch it in an ADDR_W+1-bit counter.
REQ-012 SHALL run the states in this order: POLL, read 0x78 -> CHECK.
REQ-013 CHECK SHALL go to IER_OFF if cmdRData[12:0] >= txLen+4 (13-bit compare); otherwise it SHALL increment the retry count.
REQ-014 On a failed CHECK: if retries==RETRY_MAX, SHALL pulse txErr and set txStatus=11; else SHALL wait POLL_GAP cycles and re-enter POLL.
REQ-015 IER_OFF SHALL write 0x0000 to 0x90.
REQ-016 RXQ_RD SHALL read 0x82; RXQ_SET SHALL write cmdRData|0x0008 to 0x82.
REQ-017 HDR_CTL SHALL make a dummy write of 16'h8000 | frameId[5:0]; frameId increments per accepted frame, wraps at 63.
REQ-018 HDR_LEN SHALL make a dummy write of txLen zero-extended to 16 bits.
REQ-019 DATA SHALL make exactly `words` dummy writes.
REQ-020 For each DATA word SHALL drive bufAddr=index for 2 cycles, capture bufData into cmdWData at the end of the second cycle, then assert cmdReq.
REQ-021 bufAddr SHALL start at 0 each frame and hold its last value outside DATA.
REQ-022 RXQ_RD2 SHALL read 0x82; RXQ_CLR SHALL write cmdRData & ~0x0008 to 0x82.
REQ-023 TXQ_RD SHALL read 0x80; TXQ_ENQ SHALL write cmdRData|0x0001 to 0x80.
REQ-024 IER_ON SHALL write IER_VALUE to 0x90.
REQ-025 DONE SHALL pulse txDone, increment frameCount, set txStatus=10, return to IDLE.
REQ-026 cmdDummy SHALL be 1 only for HDR_CTL, HDR_LEN and DATA accesses.
REQ-027 txBusy SHALL be 1 from the cycle after an accepted txStart until the cycle txDone or txErr pulses.

Reset
REQ-028 On reset low, asynchronously: state IDLE; every output and counter to 0 (txStatus=00, frameCount=0, frameId=0, bufAddr=0); retries=0.
REQ-029 Reset mid-sequence SHALL abort with no cleanup accesses and no txDone/txErr pulse.

Verification
REQ-030 txLen=60, TXMIR read 0x0800 -> writes in order: 0x90=0000, 0x82|8, dummy 8000, dummy 003C, 30 dummy words from bufAddr 0..29, 0x82&~8, 0x80|1, 0x90=6000; then txDone, frameCount=1.
REQ-031 txLen=61 -> 32 data words; txLen=1 -> 2 data words.
REQ-032 TXMIR returns 0x0010 for every poll, txLen=60 -> 8 polls spaced by at least 256 cycles, then txErr, txStatus=11, and no write is issued.
REQ-033 txLen=0 and txLen=2001 -> txErr one cycle after txStart, cmdReq never asserted.
REQ-034 txStart pulsed during DATA -> ignored, word count unchanged; three back-to-back frames -> HDR_CTL frame IDs 0, 1, 2.
REQ-035 reset asserted during DATA -> all outputs 0 immediately; a new txStart after release starts at POLL.
